// File: rtl/ysyx_22041211_mem_arbiter.sv
// Memory port arbiter: shares one memory port between IFU and LSU.
// One outstanding transaction, LSU priority, watchdog error response.
module ysyx_22041211_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ifu_req_valid,
    output logic                    ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   ifu_req_addr,
    output logic                    ifu_rsp_valid,
    input  logic                    ifu_rsp_ready,
    output logic [DATA_WIDTH-1:0]   ifu_rsp_rdata,
    output logic                    ifu_rsp_err,
    input  logic                    lsu_req_valid,
    output logic                    lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
    input  logic                    lsu_req_wen,
    input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] lsu_req_wmask,
    output logic                    lsu_rsp_valid,
    input  logic                    lsu_rsp_ready,
    output logic [DATA_WIDTH-1:0]   lsu_rsp_rdata,
    output logic                    lsu_rsp_err,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    output logic                    mem_req_wen,
    output logic [DATA_WIDTH-1:0]   mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
    input  logic                    mem_rsp_valid,
    output logic                    mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
    output logic                    busy,
    output logic [1:0]              grant
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ERR
    } state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wmask_q, wmask_d;

    logic own_rsp_ready;
    logic tmo;

    assign own_rsp_ready = owner_q ? lsu_rsp_ready : ifu_rsp_ready;
    assign tmo           = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;
    assign busy          = (state_q != S_IDLE);
    assign grant         = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    // State and latched-request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    // Next state: accept, forward, complete or time out
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        if ((state_q == S_REQ || state_q == S_WAIT) && cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (lsu_req_valid) begin
                    state_d = S_REQ;
                    owner_d = 1'b1;
                    cnt_d   = '0;
                    addr_d  = lsu_req_addr;
                    wen_d   = lsu_req_wen;
                    wdata_d = lsu_req_wdata;
                    wmask_d = lsu_req_wmask;
                end else if (ifu_req_valid) begin
                    state_d = S_REQ;
                    owner_d = 1'b0;
                    cnt_d   = '0;
                    addr_d  = ifu_req_addr;
                    wen_d   = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end else if (tmo) begin
                    state_d = S_ERR;
                end
            end
            S_WAIT: begin
                if (mem_rsp_valid && own_rsp_ready) begin
                    state_d = S_IDLE;
                end else if (tmo) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                if (own_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs and response routing to the owner
    always_comb begin
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_rdata = '0;
        ifu_rsp_err   = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rsp_rdata = '0;
        lsu_rsp_err   = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                lsu_req_ready = !rst;
                ifu_req_ready = !rst && !lsu_req_valid;
                mem_rsp_ready = !rst;
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
            end
            S_WAIT: begin
                mem_rsp_ready = own_rsp_ready;
                if (owner_q) begin
                    lsu_rsp_valid = mem_rsp_valid;
                    lsu_rsp_rdata = mem_rsp_valid ? mem_rsp_rdata : '0;
                end else begin
                    ifu_rsp_valid = mem_rsp_valid;
                    ifu_rsp_rdata = mem_rsp_valid ? mem_rsp_rdata : '0;
                end
            end
            S_ERR: begin
                if (owner_q) begin
                    lsu_rsp_valid = 1'b1;
                    lsu_rsp_err   = 1'b1;
                end else begin
                    ifu_rsp_valid = 1'b1;
                    ifu_rsp_err   = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
